pipeline_control_idt_write: RTL

Write-back engine for the Interrupt Descriptor Table. On a start pulse it reads all 64 entries of the Interrupt Configuration Table (ICT) and stores each one as a 32-bit word at `IDTR + entry*8`, using the shared load/store port. It sits in pipeline control next to the IDT read engine and uses the same IDT word format, so a read-back restores exactly what was written. It pulses a finish flag after every write has been acknowledged.

---
 rtl/pipeline_control_idt_write_if.sv | 22 ++
 rtl/pipeline_control_idt_write.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipeline_control_idt_write_if.sv
// Load/store port bundle between the IDT write-back engine (master) and the
// shared load/store unit (slave).
interface pipeline_control_idt_write_if;
  logic        oLDST_USE;
  logic        oLDST_REQ;
  logic        iLDST_BUSY;
  logic [1:0]  oLDST_ORDER;
  logic        oLDST_RW;
  logic [31:0] oLDST_ADDR;
  logic [31:0] oLDST_DATA;
  logic        iLDST_REQ;

  modport master (
    output oLDST_USE, oLDST_REQ, oLDST_ORDER, oLDST_RW, oLDST_ADDR, oLDST_DATA,
    input  iLDST_BUSY, iLDST_REQ
  );

  modport slave (
    input  oLDST_USE, oLDST_REQ, oLDST_ORDER, oLDST_RW, oLDST_ADDR, oLDST_DATA,
    output iLDST_BUSY, iLDST_REQ
  );
endinterface

// File: rtl/pipeline_control_idt_write.sv
// IDT write-back engine: copies all 64 ICT entries to memory at IDTR + 8*entry
// over the shared load/store port, then pulses oWR_FINISH once every write is acked.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | port released, waiting for iWR_START
// ST_FETCH | ICT entry addressed by the issue count is packed into word_q
// ST_REQ   | write request for the current entry, held while port is busy
// ST_DRAIN | all 64 writes issued, waiting for outstanding acknowledges
// ST_DONE  | one-cycle finish pulse, then back to idle
module pipeline_control_idt_write (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic [31:0] iSYSREG_IDTR,
  input  logic        iWR_START,
  output logic        oWR_FINISH,
  output logic [5:0]  oICT_RD_ENTRY,
  input  logic        iICT_CONF_MASK,
  input  logic        iICT_CONF_VALID,
  input  logic [1:0]  iICT_CONF_LEVEL,
  pipeline_control_idt_write_if.master ldst
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_REQ   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [6:0] ENTRY_TOTAL = 7'd64;
  localparam logic [6:0] ENTRY_LAST  = 7'd63;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] word_q, word_d;
  logic [6:0]  issue_cnt_q, issue_cnt_d;
  logic [6:0]  ack_cnt_q, ack_cnt_d;

  logic        in_flight;
  logic        accept;
  logic        ack_count_en;
  logic [31:0] ict_word;
  logic [31:0] wr_addr;

  assign ict_word = {14'h0, iICT_CONF_LEVEL, 14'h0, iICT_CONF_MASK, iICT_CONF_VALID};
  // Stride of 8 bytes; the add wraps modulo 2^32 so a high base rolls over to 0.
  assign wr_addr  = base_q + {23'h0, issue_cnt_q[5:0], 3'h0};

  assign in_flight    = (state_q == ST_FETCH) || (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign accept       = (state_q == ST_REQ) && !ldst.iLDST_BUSY;
  assign ack_count_en = in_flight && ldst.iLDST_REQ && (ack_cnt_q < ENTRY_TOTAL);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q     <= ST_IDLE;
      base_q      <= 32'h0;
      word_q      <= 32'h0;
      issue_cnt_q <= 7'h0;
      ack_cnt_q   <= 7'h0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      word_q      <= word_d;
      issue_cnt_q <= issue_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    word_d      = word_q;
    issue_cnt_d = issue_cnt_q;
    ack_cnt_d   = ack_cnt_q;

    if (ack_count_en) begin
      ack_cnt_d = ack_cnt_q + 7'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (iWR_START) begin
          base_d      = iSYSREG_IDTR;
          issue_cnt_d = 7'h0;
          ack_cnt_d   = 7'h0;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        word_d  = ict_word;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (accept) begin
          issue_cnt_d = issue_cnt_q + 7'd1;
          state_d     = (issue_cnt_q == ENTRY_LAST) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // Uses the registered count, so an ack in the final accept cycle still lets DRAIN last one cycle.
        if (ack_cnt_q == ENTRY_TOTAL) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (iRESET_SYNC) begin
      state_d     = ST_IDLE;
      base_d      = 32'h0;
      word_d      = 32'h0;
      issue_cnt_d = 7'h0;
      ack_cnt_d   = 7'h0;
    end
  end

  assign oWR_FINISH       = (state_q == ST_DONE);
  assign oICT_RD_ENTRY    = issue_cnt_q[5:0];
  assign ldst.oLDST_USE   = (state_q != ST_IDLE);
  assign ldst.oLDST_REQ   = (state_q == ST_REQ);
  assign ldst.oLDST_ORDER = 2'h2;
  assign ldst.oLDST_RW    = 1'b1;
  assign ldst.oLDST_ADDR  = (state_q == ST_REQ) ? wr_addr : 32'h0;
  assign ldst.oLDST_DATA  = (state_q == ST_REQ) ? word_q : 32'h0;

endmodule
